alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 36 +++
 rtl/mdu_iter.sv | 91 +++++++++
 rtl/alu_seq.sv | 118 +++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and iterative-unit op encoding
// for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_ADD    = 4'b0010;
  localparam logic [3:0] OP_ADDMSB = 4'b0011;
  localparam logic [3:0] OP_ANDN   = 4'b0100;
  localparam logic [3:0] OP_ORN    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_SLT    = 4'b0111;
  localparam logic [3:0] OP_MUL    = 4'b1000;
  localparam logic [3:0] OP_MULH   = 4'b1001;
  localparam logic [3:0] OP_DIVU   = 4'b1010;
  localparam logic [3:0] OP_REMU   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Order matches F[1:0] of the iterative opcodes so a cast selects the op.
  typedef enum logic [1:0] {
    MDU_MUL  = 2'd0,
    MDU_MULH = 2'd1,
    MDU_DIVU = 2'd2,
    MDU_REMU = 2'd3
  } mdu_op_t;

  function automatic logic is_iter_op(input logic [3:0] f);
    return f[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per
// cycle; done pulses on the cycle the WIDTH-th iteration is performed.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  mdu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc;     // product, or quotient in the low half
  logic [WIDTH:0]     rem;     // partial remainder
  logic [WIDTH-1:0]   opa;     // multiplicand or divisor
  mdu_op_t            op_q;
  logic               active;
  logic [CW-1:0]      cnt;

  logic               is_div;
  logic               last;
  logic [WIDTH:0]     add_hi;
  logic [WIDTH+1:0]   rem_sh;
  logic [WIDTH+1:0]   trial;

  assign is_div = (op_q == MDU_DIVU) || (op_q == MDU_REMU);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign done   = active && last;

  // Carry out of the high-half add is kept and shifted down, so no bit is lost.
  assign add_hi = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opa : '0)};
  assign rem_sh = {rem, acc[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, opa};

  // NOTE: every register here is state, so it is reset and updated with
  // non-blocking assignments only; blocking would race against other blocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      rem    <= '0;
      opa    <= '0;
      op_q   <= MDU_MUL;
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      op_q   <= op;
      rem    <= '0;
      cnt    <= '0;
      active <= 1'b1;
      if (op == MDU_DIVU || op == MDU_REMU) begin
        acc <= {{WIDTH{1'b0}}, a};
        opa <= b;
      end else begin
        acc <= {{WIDTH{1'b0}}, b};
        opa <= a;
      end
    end else if (active) begin
      cnt <= cnt + 1'b1;
      if (last) active <= 1'b0;
      if (is_div) begin
        if (!trial[WIDTH+1]) begin
          rem            <= trial[WIDTH:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b1};
        end else begin
          rem            <= rem_sh[WIDTH:0];
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= {add_hi, acc[WIDTH-1:1]};
      end
    end
  end

  // NOTE: a default before the case keeps this purely combinational (no latch).
  always_comb begin
    result = acc[WIDTH-1:0];
    case (op_q)
      MDU_MULH: result = acc[2*WIDTH-1:WIDTH];
      MDU_REMU: result = rem[WIDTH-1:0];
      default:  result = acc[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: single-cycle logic/add ops inline,
// multiply/divide delegated to mdu_iter, results held until consumed.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y,
  output logic             Zero,
  output logic             Ovf
);

  localparam int MSB = WIDTH - 1;

  state_t           state, state_n;
  logic             accept;
  logic             div_by_zero;
  logic             go_iter;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] fast_y;
  logic             fast_ovf;
  logic [WIDTH-1:0] y_q;
  logic             ovf_q;
  logic             y_from_mdu;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_result;

  assign div_by_zero = F[1] && (B == '0);
  assign go_iter     = is_iter_op(F) && !div_by_zero;

  assign b_eff = F[2] ? ~B : B;
  assign sum   = A + b_eff + {{(WIDTH-1){1'b0}}, F[2]};

  always_comb begin
    fast_y   = '0;
    fast_ovf = 1'b0;
    if (!F[3]) begin
      case (F[1:0])
        2'b00: fast_y = A & b_eff;
        2'b01: fast_y = A | b_eff;
        2'b10: begin
          fast_y   = sum;
          fast_ovf = F[2] ? ((A[MSB] != B[MSB]) && (sum[MSB] != A[MSB]))
                          : ((A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]));
        end
        default: fast_y = {{(WIDTH-1){1'b0}}, sum[MSB]};
      endcase
    end else if (!F[2] && div_by_zero) begin
      fast_y = F[0] ? A : '1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: if (mdu_done) state_n = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    accept = in_valid && in_ready;
    if (accept) state_n = go_iter ? ST_BUSY : ST_DONE;
  end

  // Single-cycle results are registered here; iterative results are read
  // straight from mdu_iter, whose registers freeze once it finishes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q        <= '0;
      ovf_q      <= 1'b0;
      y_from_mdu <= 1'b0;
    end else if (accept && !go_iter) begin
      y_q        <= fast_y;
      ovf_q      <= fast_ovf;
      y_from_mdu <= 1'b0;
    end else if (state == ST_BUSY && mdu_done) begin
      ovf_q      <= 1'b0;
      y_from_mdu <= 1'b1;
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .reset  (reset),
    .start  (accept && go_iter),
    .op     (mdu_op_t'(F[1:0])),
    .a      (A),
    .b      (B),
    .done   (mdu_done),
    .result (mdu_result)
  );

  assign Y    = y_from_mdu ? mdu_result : y_q;
  assign Zero = (Y == '0);
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: transaction-level reference model with a
// per-cycle compare process, directed scenarios and randomized traffic.
module tb_alu_seq;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic [3:0]    F = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  Y;
  logic          Zero;
  logic          Ovf;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .Zero      (Zero),
    .Ovf       (Ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: {ovf, y}
  function automatic logic [W:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] f);
    logic [63:0]  p;
    logic [W-1:0] y;
    logic [W-1:0] s;
    logic [W-1:0] d;
    logic         o;
    p = {32'd0, a} * {32'd0, b};
    s = a + b;
    d = a - b;
    y = '0;
    o = 1'b0;
    case (f)
      4'd0:  y = a & b;
      4'd1:  y = a | b;
      4'd2:  begin y = s; o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
      4'd3:  y = {31'd0, s[W-1]};
      4'd4:  y = a & ~b;
      4'd5:  y = a | ~b;
      4'd6:  begin y = d; o = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]); end
      4'd7:  y = {31'd0, d[W-1]};
      4'd8:  y = p[31:0];
      4'd9:  y = p[63:32];
      4'd10: y = (b == 0) ? '1 : a / b;
      4'd11: y = (b == 0) ? a : a % b;
      default: y = '0;
    endcase
    return {o, y};
  endfunction

  function automatic int model_lat(input logic [W-1:0] b, input logic [3:0] f);
    if (f[3:2] == 2'b10 && !(f[1] && b == 0)) return W + 1;
    return 1;
  endfunction

  // Model: one outstanding transaction, visible once its countdown expires.
  logic         m_pending;
  int           m_rem;
  logic [W-1:0] m_y;
  logic         m_ovf;
  logic         m_visible;
  logic         m_ready;

  assign m_visible = m_pending && (m_rem == 0);
  assign m_ready   = !m_pending || (m_visible && out_ready);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pending <= 1'b0;
      m_rem     <= 0;
      m_y       <= '0;
      m_ovf     <= 1'b0;
    end else if (in_valid && m_ready) begin
      m_pending      <= 1'b1;
      m_rem          <= model_lat(B, F) - 1;
      {m_ovf, m_y}   <= model_op(A, B, F);
    end else if (m_visible && out_ready) begin
      m_pending <= 1'b0;
    end else if (m_pending && m_rem != 0) begin
      m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
    check("out_valid", {63'd0, out_valid}, {63'd0, m_visible});
    if (m_visible) begin
      check("Y", {32'd0, Y}, {32'd0, m_y});
      check("Zero", {63'd0, Zero}, {63'd0, (m_y == 0)});
      check("Ovf", {63'd0, Ovf}, {63'd0, m_ovf});
    end
    if (!reset) begin
      check("rst_Y", {32'd0, Y}, 64'd0);
      check("rst_Zero", {63'd0, Zero}, 64'd1);
      check("rst_Ovf", {63'd0, Ovf}, 64'd0);
    end
  end

  // Offer a transaction until accepted, then scramble the operand inputs.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    logic r;
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    A = a;
    B = b;
    F = f;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      ok = r;
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    A = $urandom;
    B = $urandom;
    F = 4'($urandom_range(0, 15));
  endtask

  // Returns at the negedge where out_valid is first seen.
  task automatic get(output logic [W-1:0] y, output logic z, output logic o, output int lat);
    logic found;
    found = 1'b0;
    lat = 1;
    y = '0;
    z = 1'b0;
    o = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        y = Y;
        z = Zero;
        o = Ovf;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    if (!found) check("get_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] f, input logic [W-1:0] ey, input logic ez,
                       input logic eo, input int elat);
    logic [W-1:0] y;
    logic z, o;
    int lat;
    send(a, b, f);
    get(y, z, o, lat);
    check({name, ".y"}, {32'd0, y}, {32'd0, ey});
    check({name, ".zero"}, {63'd0, z}, {63'd0, ez});
    check({name, ".ovf"}, {63'd0, o}, {63'd0, eo});
    check({name, ".lat"}, 64'(lat), 64'(elat));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] y;
    logic z, o;
    int lat;

    #1 reset = 1'b0;
    #12;
    check("reset.in_ready", {63'd0, in_ready}, 64'd1);
    check("reset.out_valid", {63'd0, out_valid}, 64'd0);
    check("reset.Y", {32'd0, Y}, 64'd0);
    check("reset.Zero", {63'd0, Zero}, 64'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b1, 1);
    do_op("sub_zero", 32'd5, 32'd5, 4'b0110, 32'd0, 1'b1, 1'b0, 1);
    do_op("slt", 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0, 1);
    do_op("andn", 32'hF0F0_FFFF, 32'h00FF_000F, 4'b0100, 32'hF000_FFF0, 1'b0, 1'b0, 1);
    do_op("mul", 32'h0001_0000, 32'h0001_0000, 4'b1000, 32'd0, 1'b1, 1'b0, 33);
    do_op("mulh", 32'h0001_0000, 32'h0001_0000, 4'b1001, 32'd1, 1'b0, 1'b0, 33);
    do_op("mulh_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33);
    do_op("divu", 32'd100, 32'd7, 4'b1010, 32'd14, 1'b0, 1'b0, 33);
    do_op("remu", 32'd100, 32'd7, 4'b1011, 32'd2, 1'b0, 1'b0, 33);
    do_op("divu0", 32'd9, 32'd0, 4'b1010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
    do_op("remu0", 32'd9, 32'd0, 4'b1011, 32'd9, 1'b0, 1'b0, 1);
    do_op("op11xx", 32'd9, 32'd3, 4'b1101, 32'd0, 1'b1, 1'b0, 1);

    // Backpressure: result held for 5 cycles, then consumed alongside a new op.
    out_ready = 1'b0;
    send(32'd1, 32'd2, 4'b0010);
    get(y, z, o, lat);
    check("bp.y", {32'd0, y}, 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("bp.hold_y", {32'd0, Y}, 64'd3);
      check("bp.in_ready", {63'd0, in_ready}, 64'd0);
      check("bp.out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    A = 32'h0000_00F0;
    B = 32'h0000_000F;
    F = 4'b0001;
    @(negedge clk);
    check("bp.same_cycle_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp.next_valid", {63'd0, out_valid}, 64'd1);
    check("bp.next_y", {32'd0, Y}, 64'h0000_00FF);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply.
    send(32'd3, 32'd5, 4'b1000);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort.out_valid", {63'd0, out_valid}, 64'd0);
    check("abort.in_ready", {63'd0, in_ready}, 64'd1);
    check("abort.Y", {32'd0, Y}, 64'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort.ready_after", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    do_op("add_after_rst", 32'd3, 32'd4, 4'b0010, 32'd7, 1'b0, 1'b0, 1);

    // Randomized traffic; the compare process checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      F = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: A = 32'h7FFF_FFFF;
        1: A = 32'h8000_0000;
        2: A = 32'($urandom_range(0, 255));
        default: A = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: B = '0;
        1: B = 32'($urandom_range(1, 15));
        2: B = 32'hFFFF_FFFF;
        default: B = $urandom;
      endcase
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
